ext_bus_ctrl: RTL and testbench
===============================

Name: ext_bus_ctrl

Overview:
Sequencer and arbiter for the external multiplexed 8051 bus (P0 address/data, P2 high address, ALE, PSEN, RD, WR). It serves two requesters: the instruction-fetch path (code reads) and the MOVX path (XDATA read/write). It grants one requester at a time and runs the address-latch / strobe / capture sequence. It returns data with a single-cycle ack pulse.

Parameters:
STROBE_CYC, 2, number of cycles PSEN/RD/WR is held low; legal range 1..15.

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-low reset
if_req  input  1  fetch request, held high until if_ack seen
if_addr  input  16  code address
if_ack  output  1  one-cycle pulse: if_data valid
if_data  output  8  fetched byte
dx_req  input  1  XDATA request, held high until dx_ack seen
dx_we  input  1  1 = write, 0 = read
dx_addr  input  16  XDATA address
dx_wdata  input  8  write data
dx_ack  output  1  one-cycle pulse: transfer complete, dx_rdata valid on reads
dx_rdata  output  8  read byte
busy  output  1  high whenever state != IDLE
ALE  output  1  address latch enable, high effective
PSEN  output  1  program strobe, low effective
RD  output  1  XDATA read strobe, low effective
WR  output  1  XDATA write strobe, low effective
P0_out  output  8  P0 drive value
P0_oe  output  1  P0 output enable
P0_in  input  8  P0 pad input
P2_out  output  8  high address byte

Behaviour:
- Reset (reset=0 at an edge, from any state, including mid-strobe): state=IDLE, ALE=0, PSEN=RD=WR=1, P0_oe=0, P0_out=8'hFF, P2_out=8'hFF, if_ack=dx_ack=0, if_data=dx_rdata=0, cnt=0, last_grant=DX (so a fetch wins the first tie). No ack is issued for an aborted transfer.
- All outputs are registered.
- States and transitions:
  - IDLE: no request -> stay. Requests are sampled at the edge.
  - IDLE with exactly one request -> grant it.
  - IDLE with both requests -> grant the requester that is not last_grant, then update last_grant.
  - Grant edge: capture addr, dx_we and dx_wdata into internal registers. Requester inputs are ignored after this until the next IDLE.
  - IDLE -> ADDR.
  - ADDR (1 cycle): ALE=1, P0_oe=1, P0_out=addr[7:0], P2_out=addr[15:8].
  - ADDR -> LATCH (1 cycle): ALE=0, address still driven on P0/P2.
  - LATCH -> STROBE (STROBE_CYC cycles, counted by cnt):
    - Fetch: PSEN=0, P0_oe=0.
    - Read: RD=0, P0_oe=0.
    - Write: WR=0, P0_oe=1, P0_out=wdata.
  - STROBE: on the edge ending the last strobe cycle, capture P0_in into if_data or dx_rdata (reads only).
  - STROBE -> RECOVER (1 cycle): all strobes =1, the granted ack=1. For writes P0_oe stays 1 with wdata (hold time); otherwise P0_oe=0.
  - RECOVER -> IDLE unconditionally. ack returns to 0; P0_oe=0. P2_out holds its last value.
- Latency: the ack cycle is 3+STROBE_CYC cycles after the grant edge (5 for the default). Minimum period between transaction starts is 4+STROBE_CYC cycles because of the mandatory IDLE cycle.
- Handshake:
  - The requester deasserts req on the edge where it samples ack=1, so req is low in the following IDLE.
  - The block never issues two acks for one req.
  - Changing addr or data while req is high and not yet granted is allowed; values are taken at the grant edge.
- Mutual exclusion:
  - At most one of PSEN, RD, WR is low in any cycle.
  - ALE is never high while any strobe is low.
  - if_ack and dx_ack are never high together.
- STROBE_CYC=1: STROBE lasts one cycle and capture happens at its end.
- Read data outputs hold their value until the next capture or reset.

Test Plan:
- Single fetch, if_addr=16'h1234, P0_in=8'hA5, default params -> ALE high 1 cycle with P0_out=8'h34 and P2_out=8'h12; PSEN low 2 cycles; if_ack pulse 5 cycles after grant; if_data=8'hA5.
- MOVX write, dx_addr=16'h00F0, dx_wdata=8'h5C, dx_we=1 -> WR low 2 cycles; P0_out=8'h5C with P0_oe=1 through RECOVER; PSEN and RD stay 1; single dx_ack; dx_rdata unchanged.
- if_req and dx_req both raised in the same cycle after reset, each re-raised after its ack -> order is fetch, XDATA, fetch, XDATA; the other ack never overlaps.
- Reset asserted in the 1st STROBE cycle of a read -> next cycle RD=1, P0_oe=0, P2_out=8'hFF, no dx_ack; a request after reset completes normally.
- STROBE_CYC=1, XDATA read at 16'hBEEF with P0_in=8'h3C -> RD low exactly 1 cycle; dx_ack 4 cycles after grant; dx_rdata=8'h3C.
- dx_addr changed from 16'h0010 to 16'h0020 one cycle after grant -> P0/P2 still drive 16'h0010 for the whole transaction.

Source files
------------

// File: rtl/ext_bus_ctrl_if.sv
// Request/ack handshake and external 8051 multiplexed bus pins for ext_bus_ctrl.
// master = requesters plus pad side; slave = the bus controller.
interface ext_bus_ctrl_if;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_ack;
  logic [7:0]  if_data;
  logic        dx_req;
  logic        dx_we;
  logic [15:0] dx_addr;
  logic [7:0]  dx_wdata;
  logic        dx_ack;
  logic [7:0]  dx_rdata;
  logic        busy;
  logic        ALE;
  logic        PSEN;
  logic        RD;
  logic        WR;
  logic [7:0]  P0_out;
  logic        P0_oe;
  logic [7:0]  P0_in;
  logic [7:0]  P2_out;

  modport master (
    output if_req, if_addr, dx_req, dx_we, dx_addr, dx_wdata, P0_in,
    input  if_ack, if_data, dx_ack, dx_rdata, busy, ALE, PSEN, RD, WR,
           P0_out, P0_oe, P2_out
  );

  modport slave (
    input  if_req, if_addr, dx_req, dx_we, dx_addr, dx_wdata, P0_in,
    output if_ack, if_data, dx_ack, dx_rdata, busy, ALE, PSEN, RD, WR,
           P0_out, P0_oe, P2_out
  );
endinterface

// File: rtl/ext_bus_ctrl.sv
// External 8051 bus sequencer: arbitrates code fetch vs MOVX and runs the
// ALE / strobe / capture sequence with fully registered pin outputs.
module ext_bus_ctrl #(
  parameter int unsigned STROBE_CYC = 2
) (
  input logic          clk,
  input logic          reset,
  ext_bus_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LATCH,
    S_STROBE,
    S_RECOVER
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(STROBE_CYC - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_dx_q, last_dx_d;
  logic        gnt_dx_q, gnt_dx_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;

  logic        ale_q, ale_d;
  logic        psen_q, psen_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [7:0]  p0_out_q, p0_out_d;
  logic        p0_oe_q, p0_oe_d;
  logic [7:0]  p2_out_q, p2_out_d;
  logic        if_ack_q, if_ack_d;
  logic        dx_ack_q, dx_ack_d;
  logic [7:0]  if_data_q, if_data_d;
  logic [7:0]  dx_rdata_q, dx_rdata_d;
  logic        busy_q, busy_d;

  logic        pick_dx;
  logic [15:0] req_addr;
  logic        strobe_on;

  // Tie goes to whichever requester was not served last.
  assign pick_dx  = bus.dx_req && (!bus.if_req || !last_dx_q);
  assign req_addr = pick_dx ? bus.dx_addr : bus.if_addr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      last_dx_q  <= 1'b1;
      gnt_dx_q   <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ale_q      <= 1'b0;
      psen_q     <= 1'b1;
      rd_q       <= 1'b1;
      wr_q       <= 1'b1;
      p0_out_q   <= '1;
      p0_oe_q    <= 1'b0;
      p2_out_q   <= '1;
      if_ack_q   <= 1'b0;
      dx_ack_q   <= 1'b0;
      if_data_q  <= '0;
      dx_rdata_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_dx_q  <= last_dx_d;
      gnt_dx_q   <= gnt_dx_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ale_q      <= ale_d;
      psen_q     <= psen_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      p0_out_q   <= p0_out_d;
      p0_oe_q    <= p0_oe_d;
      p2_out_q   <= p2_out_d;
      if_ack_q   <= if_ack_d;
      dx_ack_q   <= dx_ack_d;
      if_data_q  <= if_data_d;
      dx_rdata_q <= dx_rdata_d;
      busy_q     <= busy_d;
    end
  end

  // Outputs are computed for the state being entered so every pin is a flop.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_dx_d  = last_dx_q;
    gnt_dx_d   = gnt_dx_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ale_d      = 1'b0;
    psen_d     = 1'b1;
    rd_d       = 1'b1;
    wr_d       = 1'b1;
    p0_out_d   = p0_out_q;
    p0_oe_d    = 1'b0;
    p2_out_d   = p2_out_q;
    if_ack_d   = 1'b0;
    dx_ack_d   = 1'b0;
    if_data_d  = if_data_q;
    dx_rdata_d = dx_rdata_q;
    strobe_on  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.if_req || bus.dx_req) begin
          state_d   = S_ADDR;
          gnt_dx_d  = pick_dx;
          last_dx_d = pick_dx;
          we_d      = pick_dx && bus.dx_we;
          addr_d    = req_addr;
          wdata_d   = bus.dx_wdata;
          ale_d     = 1'b1;
          p0_oe_d   = 1'b1;
          p0_out_d  = req_addr[7:0];
          p2_out_d  = req_addr[15:8];
        end
      end
      S_ADDR: begin
        state_d  = S_LATCH;
        cnt_d    = '0;
        p0_oe_d  = 1'b1;
        p0_out_d = addr_q[7:0];
      end
      S_LATCH: begin
        state_d   = S_STROBE;
        strobe_on = 1'b1;
      end
      S_STROBE: begin
        if (cnt_q == LAST_CNT) begin
          state_d = S_RECOVER;
          cnt_d   = '0;
          if_ack_d = !gnt_dx_q;
          dx_ack_d = gnt_dx_q;
          if (!we_q) begin
            if (gnt_dx_q) dx_rdata_d = bus.P0_in;
            else          if_data_d  = bus.P0_in;
          end
          if (we_q) begin
            p0_oe_d  = 1'b1;
            p0_out_d = wdata_q;
          end
        end else begin
          cnt_d     = cnt_q + 4'd1;
          strobe_on = 1'b1;
        end
      end
      S_RECOVER: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (strobe_on) begin
      psen_d  = gnt_dx_q;
      rd_d    = !(gnt_dx_q && !we_q);
      wr_d    = !we_q;
      p0_oe_d = we_q;
      if (we_q) p0_out_d = wdata_q;
    end

    busy_d = (state_d != S_IDLE);
  end

  assign bus.ALE      = ale_q;
  assign bus.PSEN     = psen_q;
  assign bus.RD       = rd_q;
  assign bus.WR       = wr_q;
  assign bus.P0_out   = p0_out_q;
  assign bus.P0_oe    = p0_oe_q;
  assign bus.P2_out   = p2_out_q;
  assign bus.if_ack   = if_ack_q;
  assign bus.dx_ack   = dx_ack_q;
  assign bus.if_data  = if_data_q;
  assign bus.dx_rdata = dx_rdata_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_ext_bus_ctrl.sv
// Bench for ext_bus_ctrl: directed bus-sequence scenarios plus random requester
// traffic, checked every cycle against a phase-since-grant transaction model.
`timescale 1ns/1ps
module tb_ext_bus_ctrl;
  localparam int S = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;

  ext_bus_ctrl_if b();
  ext_bus_ctrl_if b2();

  ext_bus_ctrl #(.STROBE_CYC(S)) dut  (.clk(clk), .reset(reset), .bus(b));
  ext_bus_ctrl #(.STROBE_CYC(1)) dut1 (.clk(clk), .reset(reset), .bus(b2));

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: m_ph = cycles since the grant edge (0 = no transaction in flight).
  int          m_ph = 0;
  bit          m_valid = 0;
  bit          m_last_dx, m_dx, m_we;
  logic [15:0] m_addr;
  logic [7:0]  m_wd, m_p0, m_p2, m_ifd, m_dxd;

  always @(posedge clk) begin
    if (!reset) begin
      m_ph = 0; m_last_dx = 1; m_dx = 0; m_we = 0;
      m_p0 = 8'hFF; m_p2 = 8'hFF; m_ifd = 8'h00; m_dxd = 8'h00;
      m_valid = 1;
    end else if (m_ph == 0) begin
      if (b.if_req || b.dx_req) begin
        m_dx = b.dx_req && !(b.if_req && m_last_dx);
        m_last_dx = m_dx;
        m_we = m_dx && b.dx_we;
        m_addr = m_dx ? b.dx_addr : b.if_addr;
        m_wd = b.dx_wdata;
        m_ph = 1;
      end
    end else if (m_ph == S + 3) begin
      m_ph = 0;
    end else begin
      if (m_ph == S + 2 && !m_we) begin
        if (m_dx) m_dxd = b.P0_in;
        else      m_ifd = b.P0_in;
      end
      m_ph++;
    end
    if (m_ph == 1 || m_ph == 2) m_p0 = m_addr[7:0];
    if (m_ph == 1) m_p2 = m_addr[15:8];
    if (m_we && m_ph >= 3) m_p0 = m_wd;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      bit st;
      st = (m_ph >= 3) && (m_ph <= S + 2);
      chk("ALE",      b.ALE,      m_ph == 1);
      chk("PSEN",     b.PSEN,     !(st && !m_dx));
      chk("RD",       b.RD,       !(st && m_dx && !m_we));
      chk("WR",       b.WR,       !(st && m_we));
      chk("P0_oe",    b.P0_oe,    (m_ph == 1 || m_ph == 2) || (m_we && m_ph >= 3));
      chk("P0_out",   b.P0_out,   m_p0);
      chk("P2_out",   b.P2_out,   m_p2);
      chk("if_ack",   b.if_ack,   (m_ph == S + 3) && !m_dx);
      chk("dx_ack",   b.dx_ack,   (m_ph == S + 3) && m_dx);
      chk("if_data",  b.if_data,  m_ifd);
      chk("dx_rdata", b.dx_rdata, m_dxd);
      chk("busy",     b.busy,     m_ph != 0);
    end
  end

  int          r_ack_at, r_ale, r_psen, r_rd, r_wr, r_acks, r_other;
  logic [15:0] r_a1, r_a2;
  logic [7:0]  r_p0rec;
  logic        r_oerec;

  task automatic do_reset();
    @(negedge clk);
    reset = 0;
    b.if_req = 0; b.dx_req = 0; b2.if_req = 0; b2.dx_req = 0;
    repeat (2) @(negedge clk);
    reset = 1;
  endtask

  task automatic set_req(input bit sel2, input bit dx, input bit we,
                         input logic [15:0] addr, input logic [7:0] wd, input logic [7:0] p0);
    if (sel2) begin
      b2.dx_req = dx; b2.if_req = !dx; b2.dx_we = we;
      b2.dx_addr = addr; b2.if_addr = addr; b2.dx_wdata = wd; b2.P0_in = p0;
    end else begin
      b.dx_req = dx; b.if_req = !dx; b.dx_we = we;
      b.dx_addr = addr; b.if_addr = addr; b.dx_wdata = wd; b.P0_in = p0;
    end
  endtask

  // Called at a negedge; raises one request and watches 10 cycles of pins.
  task automatic run_txn(input bit sel2, input bit dx, input bit we,
                         input logic [15:0] addr, input logic [15:0] addr2,
                         input logic [7:0] wd, input logic [7:0] p0);
    logic s_ale, s_psen, s_rd, s_wr, s_oe, s_iack, s_dack, ack, other;
    logic [7:0] s_p0, s_p2;
    r_ack_at = 0; r_ale = 0; r_psen = 0; r_rd = 0; r_wr = 0; r_acks = 0; r_other = 0;
    r_a1 = '0; r_a2 = '0; r_p0rec = '0; r_oerec = 0;
    set_req(sel2, dx, we, addr, wd, p0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (sel2) begin b2.dx_addr = addr2; b2.if_addr = addr2; end
        else      begin b.dx_addr = addr2;  b.if_addr = addr2;  end
      end
      if (sel2) begin
        s_ale = b2.ALE; s_psen = b2.PSEN; s_rd = b2.RD; s_wr = b2.WR; s_oe = b2.P0_oe;
        s_iack = b2.if_ack; s_dack = b2.dx_ack; s_p0 = b2.P0_out; s_p2 = b2.P2_out;
      end else begin
        s_ale = b.ALE; s_psen = b.PSEN; s_rd = b.RD; s_wr = b.WR; s_oe = b.P0_oe;
        s_iack = b.if_ack; s_dack = b.dx_ack; s_p0 = b.P0_out; s_p2 = b.P2_out;
      end
      if (s_ale) r_ale++;
      if (!s_psen) r_psen++;
      if (!s_rd) r_rd++;
      if (!s_wr) r_wr++;
      if (k == 1) r_a1 = {s_p2, s_p0};
      if (k == 2) r_a2 = {s_p2, s_p0};
      ack = dx ? s_dack : s_iack;
      other = dx ? s_iack : s_dack;
      if (other) r_other++;
      if (ack) begin
        r_acks++;
        if (r_ack_at == 0) begin r_ack_at = k; r_p0rec = s_p0; r_oerec = s_oe; end
        if (sel2) begin b2.if_req = 0; b2.dx_req = 0; end
        else      begin b.if_req = 0;  b.dx_req = 0;  end
      end
    end
  endtask

  initial begin
    int seq, nacks, nf, nd, f_wait, d_wait, both, acks;
    b.if_req = 0; b.if_addr = '0; b.dx_req = 0; b.dx_we = 0; b.dx_addr = '0;
    b.dx_wdata = '0; b.P0_in = '0;
    b2.if_req = 0; b2.if_addr = '0; b2.dx_req = 0; b2.dx_we = 0; b2.dx_addr = '0;
    b2.dx_wdata = '0; b2.P0_in = '0;

    do_reset();
    @(negedge clk);
    chk("rst_PSEN", b.PSEN, 1'b1);
    chk("rst_P0_out", b.P0_out, 8'hFF);
    chk("rst_P2_out", b.P2_out, 8'hFF);
    chk("rst_P0_oe", b.P0_oe, 1'b0);
    chk("rst_if_data", b.if_data, 8'h00);

    // Single fetch
    run_txn(0, 0, 0, 16'h1234, 16'h1234, 8'h00, 8'hA5);
    chk("fetch_ale_cycles", r_ale, 1);
    chk("fetch_addr", r_a1, 16'h1234);
    chk("fetch_psen_cycles", r_psen, 2);
    chk("fetch_rdwr_low", r_rd + r_wr, 0);
    chk("fetch_ack_latency", r_ack_at, 5);
    chk("fetch_ack_count", r_acks, 1);
    chk("fetch_other_ack", r_other, 0);
    chk("fetch_if_data", b.if_data, 8'hA5);

    // MOVX write
    run_txn(0, 1, 1, 16'h00F0, 16'h00F0, 8'h5C, 8'h33);
    chk("wr_wr_cycles", r_wr, 2);
    chk("wr_psen_rd_low", r_psen + r_rd, 0);
    chk("wr_ack_latency", r_ack_at, 5);
    chk("wr_ack_count", r_acks, 1);
    chk("wr_recover_p0", r_p0rec, 8'h5C);
    chk("wr_recover_oe", r_oerec, 1'b1);
    chk("wr_dx_rdata_kept", b.dx_rdata, 8'h00);

    // Address changed one cycle after grant
    run_txn(0, 1, 0, 16'h0010, 16'h0020, 8'h00, 8'h77);
    chk("chg_addr_ale", r_a1, 16'h0010);
    chk("chg_addr_latch", r_a2, 16'h0010);
    chk("chg_rd_cycles", r_rd, 2);
    chk("chg_dx_rdata", b.dx_rdata, 8'h77);

    // Simultaneous requests, each re-raised after its ack
    do_reset();
    @(negedge clk);
    b.if_addr = 16'h2000; b.dx_addr = 16'h3000; b.dx_we = 0;
    b.if_req = 1; b.dx_req = 1;
    seq = 0; nacks = 0; nf = 0; nd = 0; f_wait = 0; d_wait = 0; both = 0;
    for (int k = 0; k < 80 && nacks < 4; k++) begin
      @(negedge clk);
      if (b.if_ack && b.dx_ack) both++;
      if (b.if_ack) begin
        seq = seq * 2; nacks++; nf++; b.if_req = 0; f_wait = 2;
      end else if (f_wait > 0) begin
        f_wait--;
        if (f_wait == 0 && nf < 2) b.if_req = 1;
      end
      if (b.dx_ack) begin
        seq = seq * 2 + 1; nacks++; nd++; b.dx_req = 0; d_wait = 2;
      end else if (d_wait > 0) begin
        d_wait--;
        if (d_wait == 0 && nd < 2) b.dx_req = 1;
      end
    end
    chk("arb_ack_total", nacks, 4);
    chk("arb_order", seq, 4'b0101);
    chk("arb_overlap", both, 0);
    b.if_req = 0; b.dx_req = 0;
    repeat (10) @(negedge clk);

    // Reset in the first strobe cycle of a read
    b.dx_req = 1; b.dx_we = 0; b.dx_addr = 16'h4321;
    repeat (3) @(negedge clk);
    chk("mid_rd_low", b.RD, 1'b0);
    reset = 0;
    @(negedge clk);
    chk("mid_rst_RD", b.RD, 1'b1);
    chk("mid_rst_oe", b.P0_oe, 1'b0);
    chk("mid_rst_P2", b.P2_out, 8'hFF);
    chk("mid_rst_ack", b.dx_ack, 1'b0);
    b.dx_req = 0; reset = 1;
    acks = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (b.dx_ack || b.if_ack) acks++;
    end
    chk("mid_rst_no_ack", acks, 0);
    run_txn(0, 1, 0, 16'h1111, 16'h1111, 8'h00, 8'h9A);
    chk("post_rst_latency", r_ack_at, 5);
    chk("post_rst_rdata", b.dx_rdata, 8'h9A);

    // Single-cycle strobe instance
    run_txn(1, 1, 0, 16'hBEEF, 16'hBEEF, 8'h00, 8'h3C);
    chk("s1_addr", r_a1, 16'hBEEF);
    chk("s1_rd_cycles", r_rd, 1);
    chk("s1_ack_latency", r_ack_at, 4);
    chk("s1_ack_count", r_acks, 1);
    chk("s1_dx_rdata", b2.dx_rdata, 8'h3C);

    // Random requester traffic with occasional aborting reset
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      b.P0_in = 8'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        reset = 0; b.if_req = 0; b.dx_req = 0;
      end else begin
        reset = 1;
        if (b.if_req) begin
          if (b.if_ack) b.if_req = 0;
          else if ($urandom_range(0, 3) == 0) b.if_addr = 16'($urandom);
        end else if ($urandom_range(0, 3) == 0) begin
          b.if_req = 1; b.if_addr = 16'($urandom);
        end
        if (b.dx_req) begin
          if (b.dx_ack) b.dx_req = 0;
          else if ($urandom_range(0, 3) == 0) begin
            b.dx_addr = 16'($urandom); b.dx_wdata = 8'($urandom); b.dx_we = 1'($urandom);
          end
        end else if ($urandom_range(0, 3) == 0) begin
          b.dx_req = 1; b.dx_addr = 16'($urandom);
          b.dx_wdata = 8'($urandom); b.dx_we = 1'($urandom);
        end
      end
    end
    reset = 1; b.if_req = 0; b.dx_req = 0;
    repeat (10) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
